fp_div_sequencer: RTL

//  Multi-cycle IEEE-754 single-precision divider controller: accepts a/b via valid/ready, screens special cases,

---
 rtl/fp_div_sequencer_pkg.sv | 37 +++
 rtl/fp_div_sequencer_mantissa_divider.sv | 47 ++++
 rtl/fp_div_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fp_div_sequencer_pkg.sv
// Shared single-precision definitions for the FP divide engine: field widths, the float
// struct, the controller state encoding and the operand classification helpers.
package floatingpoint;

    localparam int EXPONENT_BITS = 8;
    localparam int FRACTION_BITS = 23;
    localparam int BIAS          = 127;
    localparam int EXP_MAX       = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic                     sign;
        logic [EXPONENT_BITS-1:0] exponent;
        logic [FRACTION_BITS-1:0] fraction;
    } float_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DIVIDE    = 2'd1,
        NORMALIZE = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Denormals count as zero: the engine never consumes or produces them.
    function automatic logic iszero(input float_t f);
        return f.exponent == '0;
    endfunction

    function automatic logic isnan(input float_t f);
        return (f.exponent == '1) && (f.fraction != '0);
    endfunction

    function automatic logic isinfinity(input float_t f);
        return (f.exponent == '1) && (f.fraction == '0);
    endfunction

endpackage

// File: rtl/fp_div_sequencer_mantissa_divider.sv
// Radix-2 restoring mantissa iterator: one quotient bit per step, sequenced by the
// fp_div_sequencer FSM; `last` flags the step that produces the final quotient bit.
module mantissa_divider #(
    parameter int QBITS = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [23:0]      ma,
    input  logic [23:0]      mb,
    output logic [QBITS-1:0] q,
    output logic [24:0]      rem,
    output logic             last
);

    localparam int CW = $clog2(QBITS + 1);

    logic [CW-1:0] count;
    logic [23:0]   mb_r;
    logic          ge;
    logic [23:0]   diff;

    // The remainder stays below mb (< 2^24) after each subtract, so 24 bits hold it before the shift.
    assign ge   = rem >= {1'b0, mb_r};
    assign diff = ge ? 24'(rem - {1'b0, mb_r}) : rem[23:0];
    assign last = step && (count == CW'(QBITS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            mb_r  <= '0;
            q     <= '0;
            rem   <= '0;
        end else if (start) begin
            count <= '0;
            mb_r  <= mb;
            q     <= '0;
            rem   <= {1'b0, ma};
        end else if (step) begin
            count <= count + CW'(1);
            q     <= {q[QBITS-2:0], ge};
            rem   <= {diff, 1'b0};
        end
    end

endmodule

// File: rtl/fp_div_sequencer.sv
// Multi-cycle IEEE-754 single-precision divide controller (one op in flight).
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_div_sequencer
    import floatingpoint::*;
#(
    parameter int QBITS = FRACTION_BITS + 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        invalid,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high only
    // in IDLE, and result/flags/out_valid hold steady while out_valid && !out_ready.

    state_t             state;
    float_t             fa, fb;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic signed [9:0]  exp_init;
    logic               accept;

    logic               spec_hit, spec_inv, spec_dbz, sign_x;
    logic [31:0]        spec_res;

    logic               div_start, div_step, div_last;
    logic [QBITS-1:0]   div_q;
    logic [24:0]        div_rem;

    logic [QBITS-1:0]   q_n;
    logic signed [9:0]  e_n, e_r;
    logic [22:0]        frac_t, frac_r;
    logic               guard, sticky, inc;
    logic [23:0]        mant;
    logic               norm_ovf, norm_unf;
    logic [31:0]        norm_res;

    assign fa        = a;
    assign fb        = b;
    assign sign_x    = fa.sign ^ fb.sign;
    assign accept    = in_valid && in_ready;
    assign exp_init  = signed'({2'b00, fa.exponent} - {2'b00, fb.exponent} + 10'(BIAS));
    assign div_start = accept && (state == IDLE) && !spec_hit;
    assign div_step  = (state == DIVIDE);
    assign dbg_state = state;

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        spec_res = '0;
        if (isnan(fa) || isnan(fb) || (iszero(fa) && iszero(fb)) ||
            (isinfinity(fa) && isinfinity(fb))) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (iszero(fb) && !isinfinity(fa)) begin
            spec_res = {sign_x, 8'hFF, 23'h0};
            spec_dbz = 1'b1;
        end else if (isinfinity(fa)) begin
            spec_res = {sign_x, 8'hFF, 23'h0};
        end else if (iszero(fa) || isinfinity(fb)) begin
            spec_res = {sign_x, 31'h0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    mantissa_divider #(.QBITS(QBITS)) u_mant (
        .clock (clock),
        .reset (reset),
        .start (div_start),
        .step  (div_step),
        .ma    ({1'b1, fa.fraction}),
        .mb    ({1'b1, fb.fraction}),
        .q     (div_q),
        .rem   (div_rem),
        .last  (div_last)
    );

    // Quotient lies in (0.5, 2): at most one left shift brings the leading one to the top bit.
    always_comb begin
        q_n = div_q;
        e_n = exp_r;
        if (!div_q[QBITS-1]) begin
            q_n = div_q << 1;
            e_n = exp_r - 10'sd1;
        end
        frac_t = q_n[QBITS-2 -: FRACTION_BITS];
        guard  = q_n[QBITS-FRACTION_BITS-2];
        sticky = (|q_n[QBITS-FRACTION_BITS-3:0]) || (div_rem != '0);
`ifdef FP_ROUND_NEAREST_EN
        inc = guard && (sticky || frac_t[0]);
`else
        inc = 1'b0;
`endif
        mant   = {1'b0, frac_t} + {23'd0, inc};
        e_r    = e_n;
        frac_r = mant[22:0];
        if (mant[23]) begin
            frac_r = '0;
            e_r    = e_n + 10'sd1;
        end
        norm_ovf = e_r >= $signed(10'(EXP_MAX));
        norm_unf = e_r <= 10'sd0;
        norm_res = {sign_r, e_r[7:0], frac_r};
        if (norm_ovf)
            norm_res = {sign_r, 8'hFF, 23'h0};
        else if (norm_unf)
            norm_res = {sign_r, 31'h0};
    end

`ifndef FP_ROUND_NEAREST_EN
    logic unused_round_bits;
    assign unused_round_bits = guard ^ sticky;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready    <= 1'b0;
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        sign_r      <= sign_x;
                        exp_r       <= exp_init;
                        invalid     <= spec_inv;
                        div_by_zero <= spec_dbz;
                        if (spec_hit) begin
                            result    <= spec_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_last)
                        state <= NORMALIZE;
                end
                NORMALIZE: begin
                    result    <= norm_res;
                    overflow  <= norm_ovf;
                    underflow <= norm_unf && !norm_ovf;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
